// File: rtl/multicycle_xpsr_flag_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_xpsr_flag_unit_if
//
// Purpose: bundles the signals between the multicycle controller/datapath
// and the xPSR flag unit. It groups the instruction and state context, the
// ALU flag sources, the direct-write path, the condition query and the flag
// results.
//
// Modports:
//   master - controller/datapath side. It drives INSTRUCTION, state,
//            alu_flags, shifter_carry, logical_op, flag_wr_en, flag_wr_data
//            and cond. It observes flagUpdate, flags, cond_pass and upd_done.
//   slave  - flag unit side. It uses the same signals with the directions
//            reversed.
//
// Optional feature macro: XPSR_SHADOW_EN adds flag_save, flag_restore and
// shadow_flags.
// ---------------------------------------------------------------------------
interface multicycle_xpsr_flag_unit_if #(
    parameter int STATE_W = 4
) ();
    logic [31:0]        INSTRUCTION;
    logic [STATE_W-1:0] state;
    logic [3:0]         alu_flags;
    logic               shifter_carry;
    logic               logical_op;
    logic               flag_wr_en;
    logic [3:0]         flag_wr_data;
    logic [3:0]         cond;
    logic               flagUpdate;
    logic [3:0]         flags;
    logic               cond_pass;
    logic               upd_done;
`ifdef XPSR_SHADOW_EN
    logic               flag_save;
    logic               flag_restore;
    logic [3:0]         shadow_flags;
`endif

    modport master (
        output INSTRUCTION, state, alu_flags, shifter_carry, logical_op,
               flag_wr_en, flag_wr_data, cond,
`ifdef XPSR_SHADOW_EN
        output flag_save, flag_restore,
        input  shadow_flags,
`endif
        input  flagUpdate, flags, cond_pass, upd_done
    );

    modport slave (
        input  INSTRUCTION, state, alu_flags, shifter_carry, logical_op,
               flag_wr_en, flag_wr_data, cond,
`ifdef XPSR_SHADOW_EN
        input  flag_save, flag_restore,
        output shadow_flags,
`endif
        output flagUpdate, flags, cond_pass, upd_done
    );
endinterface

// File: rtl/multicycle_xpsr_flag_unit.sv
// ---------------------------------------------------------------------------
// multicycle_xpsr_flag_unit
//
// Purpose: owns the NZCV flag register of the multicycle computer. The unit
// performs four jobs:
//   - It decodes in which controller states the ALU may write the flags.
//   - It arbitrates between direct (MSR-style) writes and ALU writes.
//   - It allows only one ALU flag write per instruction.
//   - It evaluates the 4-bit ARM condition field against the stored flags.
//
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - synchronous active-low reset
//   flagBus   - multicycle_xpsr_flag_unit_if.slave. It carries:
//                 INSTRUCTION, state, alu_flags, shifter_carry, logical_op,
//                 flag_wr_en, flag_wr_data, cond (inputs)
//                 flagUpdate, flags, cond_pass, upd_done (outputs)
//
// Optional feature macro: XPSR_SHADOW_EN. When it is defined, the unit has a
// shadow flag register. flag_save copies the flags into the shadow register.
// flag_restore copies the shadow register back into the flags. Asserting both
// swaps the two values.
// ---------------------------------------------------------------------------
module multicycle_xpsr_flag_unit #(
    parameter int          STATE_W       = 4,
    parameter logic [15:0] UPDATE_STATES = 16'h11C0,
    parameter int          FETCH_STATE   = 0,
    parameter int          SBIT_POS      = 20
) (
    input logic                        clk,
    input logic                        reset_n,
    multicycle_xpsr_flag_unit_if.slave flagBus
);

    logic [3:0]  flags_q,   flags_d;
    logic        updDone_q, updDone_d;
    logic [31:0] stateWide;
    logic        inUpd;
    logic        isFetch;
    logic        flagUpdate;
    logic [3:0]  aluValue;
    logic        nFlag, zFlag, cFlag, vFlag;
    logic        condPass;
`ifdef XPSR_SHADOW_EN
    logic [3:0]  shadow_q, shadow_d;
`endif

    // The mask covers only state codes 0..15. Wider state codes beyond the
    // mask are not update states.
    always_comb begin
        stateWide = 32'(flagBus.state);
        inUpd     = 1'b0;
        if (stateWide < 32'd16) begin
            inUpd = UPDATE_STATES[stateWide[3:0]];
        end
        isFetch    = (flagBus.state == STATE_W'(FETCH_STATE));
        flagUpdate = inUpd & flagBus.INSTRUCTION[SBIT_POS] & ~updDone_q
                     & ~flagBus.flag_wr_en;
    end

    // Logical ops take the carry from the barrel shifter and keep the old V.
    always_comb begin
        aluValue = flagBus.alu_flags;
        if (flagBus.logical_op) begin
            aluValue = {flagBus.alu_flags[3:2], flagBus.shifter_carry, flags_q[0]};
        end
    end

    // Next-state selection for the flag registers, lowest priority first so
    // that each later assignment overrides the earlier ones. The ALU write
    // has the lowest priority. A direct write overrides it. A restore from
    // the shadow register overrides both.
    always_comb begin
        flags_d = flags_q;
        if (flagUpdate) begin
            flags_d = aluValue;
        end
        if (flagBus.flag_wr_en) begin
            flags_d = flagBus.flag_wr_data;
        end
`ifdef XPSR_SHADOW_EN
        shadow_d = shadow_q;
        if (flagBus.flag_save) begin
            shadow_d = flags_q;
        end
        if (flagBus.flag_restore) begin
            flags_d = shadow_q;
        end
`endif
    end

    // Once-per-instruction guard. A fetch state clears the guard, and the
    // clear wins over a set on the same edge.
    always_comb begin
        updDone_d = updDone_q;
        if (flagUpdate) begin
            updDone_d = 1'b1;
        end
        if (isFetch) begin
            updDone_d = 1'b0;
        end
    end

    // State registers. The reset branch does not read any input, so an X on
    // state while reset_n is low cannot reach the registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q   <= 4'b0000;
            updDone_q <= 1'b0;
`ifdef XPSR_SHADOW_EN
            shadow_q  <= 4'b0000;
`endif
        end else begin
            flags_q   <= flags_d;
            updDone_q <= updDone_d;
`ifdef XPSR_SHADOW_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

    // ARM condition decode on the stored flags. Code F is reserved and
    // never passes.
    always_comb begin
        {nFlag, zFlag, cFlag, vFlag} = flags_q;
        condPass = 1'b0;
        case (flagBus.cond)
            4'h0: condPass = zFlag;
            4'h1: condPass = ~zFlag;
            4'h2: condPass = cFlag;
            4'h3: condPass = ~cFlag;
            4'h4: condPass = nFlag;
            4'h5: condPass = ~nFlag;
            4'h6: condPass = vFlag;
            4'h7: condPass = ~vFlag;
            4'h8: condPass = cFlag & ~zFlag;
            4'h9: condPass = ~cFlag | zFlag;
            4'hA: condPass = (nFlag == vFlag);
            4'hB: condPass = (nFlag != vFlag);
            4'hC: condPass = ~zFlag & (nFlag == vFlag);
            4'hD: condPass = zFlag | (nFlag != vFlag);
            4'hE: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    end

    assign flagBus.flagUpdate = flagUpdate;
    assign flagBus.flags      = flags_q;
    assign flagBus.upd_done   = updDone_q;
    assign flagBus.cond_pass  = condPass;
`ifdef XPSR_SHADOW_EN
    assign flagBus.shadow_flags = shadow_q;
`endif

endmodule

// File: tb/tb_multicycle_xpsr_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_xpsr_flag_unit
//
// Purpose: directed self-checking bench for multicycle_xpsr_flag_unit. The
// expected values are computed by hand from the flag-unit behaviour.
// Inputs change 1 time unit after a rising edge. Outputs are sampled before
// the next rising edge.
//
// Optional feature macro: XPSR_SHADOW_EN enables the shadow save/restore
// steps.
// ---------------------------------------------------------------------------
module tb_multicycle_xpsr_flag_unit;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    multicycle_xpsr_flag_unit_if #(.STATE_W(4)) bus ();

    multicycle_xpsr_flag_unit #(
        .STATE_W(4),
        .UPDATE_STATES(16'h11C0),
        .FETCH_STATE(0),
        .SBIT_POS(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flagBus(bus)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the sequence below never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] state, input logic sBit,
                                 input logic [3:0] alu, input logic logical,
                                 input logic shCarry, input logic wrEn,
                                 input logic [3:0] wrData);
        bus.state         = state;
        bus.INSTRUCTION   = 32'(sBit) << 20;
        bus.alu_flags     = alu;
        bus.logical_op    = logical;
        bus.shifter_carry = shCarry;
        bus.flag_wr_en    = wrEn;
        bus.flag_wr_data  = wrData;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkCond(input string tag, input logic [3:0] cond,
                             input logic expected);
        bus.cond = cond;
        #1;
        checkOutput(tag, {3'b000, bus.cond_pass}, {3'b000, expected});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n         = 1'b0;
        bus.cond        = 4'hE;
`ifdef XPSR_SHADOW_EN
        bus.flag_save    = 1'b0;
        bus.flag_restore = 1'b0;
`endif
        // Reset with a direct write of F pending and an unknown state.
        applyStimulus(4'bxxxx, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 4'hF);
        tick();
        tick();
        checkOutput("reset_flags", bus.flags, 4'b0000);
        checkOutput("reset_upd_done", {3'b000, bus.upd_done}, 4'b0000);

        reset_n = 1'b1;
        applyStimulus(4'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        checkCond("reset_cond_AL", 4'hE, 1'b1);
        checkCond("reset_cond_F", 4'hF, 1'b0);
        tick();
        checkOutput("post_reset_flags", bus.flags, 4'b0000);

        // An S=1 arithmetic op in update state 6.
        applyStimulus(4'd6, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("arith_flagUpdate", {3'b000, bus.flagUpdate}, 4'b0001);
        tick();
        checkOutput("arith_flags", bus.flags, 4'b0110);
        checkOutput("arith_upd_done", {3'b000, bus.upd_done}, 4'b0001);
        checkCond("arith_EQ", 4'h0, 1'b1);
        checkCond("arith_CS", 4'h2, 1'b1);

        // Guard: later update states in the same instruction do not write.
        applyStimulus(4'd7, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("guard_s7_flagUpdate", {3'b000, bus.flagUpdate}, 4'b0000);
        tick();
        checkOutput("guard_s7_flags", bus.flags, 4'b0110);
        applyStimulus(4'd8, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("guard_s8_flagUpdate", {3'b000, bus.flagUpdate}, 4'b0000);
        tick();
        checkOutput("guard_s8_flags", bus.flags, 4'b0110);
        applyStimulus(4'd0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        checkOutput("fetch_clears_upd", {3'b000, bus.upd_done}, 4'b0000);
        checkOutput("fetch_keeps_flags", bus.flags, 4'b0110);
        applyStimulus(4'd12, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("s12_flagUpdate", {3'b000, bus.flagUpdate}, 4'b0001);
        tick();
        checkOutput("s12_flags", bus.flags, 4'b1001);

        // A direct write does not change upd_done.
        applyStimulus(4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001);
        tick();
        checkOutput("wr_flags", bus.flags, 4'b0001);
        checkOutput("wr_keeps_upd", {3'b000, bus.upd_done}, 4'b0001);
        applyStimulus(4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();

        // Logical op: N and Z come from the ALU, C from the shifter, and V is kept.
        applyStimulus(4'd6, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 4'h0);
        tick();
        checkOutput("logical_flags", bus.flags, 4'b1011);
        applyStimulus(4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        checkOutput("logical_fetch_upd", {3'b000, bus.upd_done}, 4'b0000);

        // A direct write overrides an ALU write in the same cycle.
        applyStimulus(4'd6, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0011);
        checkOutput("prio_flagUpdate", {3'b000, bus.flagUpdate}, 4'b0000);
        tick();
        checkOutput("prio_flags", bus.flags, 4'b0011);
        checkOutput("prio_upd_done", {3'b000, bus.upd_done}, 4'b0000);
        applyStimulus(4'd6, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("s0_flagUpdate", {3'b000, bus.flagUpdate}, 4'b0000);
        tick();
        checkOutput("s0_flags", bus.flags, 4'b0011);

        // Condition sweep on flags 1001 (N=1, Z=0, C=0, V=1).
        applyStimulus(4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1001);
        tick();
        applyStimulus(4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("sweep_flags", bus.flags, 4'b1001);
        checkCond("cond_EQ", 4'h0, 1'b0);
        checkCond("cond_NE", 4'h1, 1'b1);
        checkCond("cond_CC", 4'h3, 1'b1);
        checkCond("cond_MI", 4'h4, 1'b1);
        checkCond("cond_PL", 4'h5, 1'b0);
        checkCond("cond_VS", 4'h6, 1'b1);
        checkCond("cond_VC", 4'h7, 1'b0);
        checkCond("cond_HI", 4'h8, 1'b0);
        checkCond("cond_LS", 4'h9, 1'b1);
        checkCond("cond_GE", 4'hA, 1'b1);
        checkCond("cond_LT", 4'hB, 1'b0);
        checkCond("cond_GT", 4'hC, 1'b1);
        checkCond("cond_LE", 4'hD, 1'b0);

`ifdef XPSR_SHADOW_EN
        // Save 1001, overwrite with 0000, then restore.
        bus.flag_save = 1'b1;
        tick();
        bus.flag_save = 1'b0;
        checkOutput("shadow_saved", bus.shadow_flags, 4'b1001);
        applyStimulus(4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000);
        tick();
        checkOutput("shadow_wr_zero", bus.flags, 4'b0000);
        applyStimulus(4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0110);
        bus.flag_restore = 1'b1;
        tick();
        bus.flag_restore = 1'b0;
        checkOutput("shadow_restore", bus.flags, 4'b1001);
        applyStimulus(4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
`endif

        // A reset mid-instruction wins over a pending ALU update.
        applyStimulus(4'd6, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0);
        reset_n = 1'b0;
        tick();
        checkOutput("midreset_flags", bus.flags, 4'b0000);
        checkOutput("midreset_upd_done", {3'b000, bus.upd_done}, 4'b0000);
        reset_n = 1'b1;
        tick();
        checkOutput("after_reset_update", bus.flags, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_xpsr_flag_unit.md
Name: multicycle_xpsr_flag_unit

Overview:
- Parameterised successor to the combinational xPSR write-enable decode for the multicycle computer.
- Decodes when the flags may be written. Owns the NZCV flag register, with priority between direct writes and ALU writes and a once-per-instruction write guard.
- Evaluates the 4-bit condition field against the stored flags.
- Sits beside the controller FSM and datapath ALU. Its flag outputs feed the controller's condition logic.

Parameters:
- STATE_W, 4, width of the controller state code.
- UPDATE_STATES, 16'h11C0, one bit per state code; bit k=1 means state k is a flag-update state. Default selects s6, s7, s8, s12.
- FETCH_STATE, 0, state code that marks the start of a new instruction.
- SBIT_POS, 20, bit of INSTRUCTION holding the S (set-flags) bit.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- INSTRUCTION  in  32  current instruction register.
- state  in  STATE_W  controller state code.
- alu_flags  in  4  ALU result flags {N,Z,C,V}.
- shifter_carry  in  1  barrel-shifter carry-out.
- logical_op  in  1  1 = current op is logical (AND/ORR/EOR/MOV/...).
- flag_wr_en  in  1  direct flag write (MSR-style).
- flag_wr_data  in  4  direct write value {N,Z,C,V}.
- cond  in  4  condition field to evaluate.
- flagUpdate  out  1  combinational: ALU flag write occurs this cycle.
- flags  out  4  registered {N,Z,C,V}.
- cond_pass  out  1  combinational condition result on current flags.
- upd_done  out  1  registered: the flags have already been written in this instruction.

Behaviour:
- Reset (reset_n=0 at a clk edge): flags=4'b0000, upd_done=0. Reset has priority over every other input, including mid-instruction.
- in_upd = UPDATE_STATES[state] (states beyond the mask count as not an update state).
- flagUpdate = in_upd & INSTRUCTION[SBIT_POS] & ~upd_done & ~flag_wr_en.
- ALU write value:
  - Arithmetic op: next = alu_flags.
  - logical_op=1: N and Z from alu_flags, C = shifter_carry, V keeps its old value.
- Register update priority per clk edge:
  1. reset.
  2. flag_wr_en=1: flags <= flag_wr_data. This suppresses any ALU write in the same cycle.
  3. flagUpdate=1: flags <= ALU write value.
  4. Otherwise hold.
- Latency: the new flags are visible on `flags` one cycle after the update edge. cond_pass follows on the same cycle as `flags`.
- upd_done:
  - Set on any edge where flagUpdate=1.
  - Cleared on any edge where state==FETCH_STATE. Clear wins if both occur on the same edge.
  - Effect: only the first eligible update state of an instruction writes the flags. Later update states in the same instruction do not.
- flag_wr_en does not set or clear upd_done.
- cond_pass is the ARM decode on the stored flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z.
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL =1; F =0 (reserved).
- X on state while reset_n=0 must not propagate to the outputs after reset.

Optional Feature:
- Macro: XPSR_SHADOW_EN.
- When defined:
  - Adds inputs flag_save (1) and flag_restore (1), and output shadow_flags (4). shadow_flags resets to 0.
  - flag_save=1: shadow_flags <= flags, using the pre-edge value.
  - flag_restore=1: flags <= shadow_flags. This takes priority over flag_wr_en and the ALU write, but not over reset.
  - Save and restore in the same cycle: both take effect, i.e. a swap.
- When undefined: the ports and shadow register are absent. Behaviour is exactly as above.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with flag_wr_en=1, data 4'hF -> flags=0, upd_done=0, cond=E gives cond_pass=1, cond=F gives cond_pass=0.
- S=1 arithmetic: state=6, alu_flags=4'b0110 -> flagUpdate=1 that cycle; next cycle flags=4'b0110, cond=0 (EQ) gives cond_pass=1, cond=2 (CS) gives cond_pass=1.
- Guard: flags=0110, upd_done=1; state=7 then 8 with alu_flags=1001, S=1 -> flagUpdate=0, flags stay 0110. Then state=0 -> upd_done=0; state=12 with alu 1001 -> flags=1001.
- Logical op: flags=0001, logical_op=1, shifter_carry=1, alu_flags=1000, state=6, S=1 -> flags=1011 (V kept).
- Priority: state=6, S=1, alu_flags=0100, flag_wr_en=1, data 0011 -> flagUpdate=0, flags=0011, upd_done unchanged. Same setup with S=0 and no wr_en -> flags unchanged.
- Condition sweep: flags=1001 (N=1, V=1) -> GE=1, LT=0, GT=1, LE=0, HI=0 (C=0), LS=1. With XPSR_SHADOW_EN: save, then wr 0000, then restore -> flags=1001.
